// File: rtl/if_id_buf.sv
// Buffered IF/ID boundary: small in-order FIFO of fetched address/instruction pairs
// that rides out decode stalls and discards its contents on a control flush.
module if_id_buf #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(32'h00000013)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [ADDR_WIDTH-1:0]     inst_addr_i,
  input  logic [DATA_WIDTH-1:0]     inst_i,
  input  logic                      inst_valid_i,
  output logic                      inst_ready_o,
  input  logic                      stall_i,
  input  logic                      flush_i,
  output logic [ADDR_WIDTH-1:0]     inst_addr_o,
  output logic [DATA_WIDTH-1:0]     inst_o,
  output logic                      inst_valid_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] inst;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             in_entry;
  entry_t             head_q, head_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, ready_q;
  logic               push, pop;

  assign in_entry = '{addr: inst_addr_i, inst: inst_i};

  // Handshakes only see registered occupancy flags, so ready has no input path.
  assign push = inst_valid_i & ready_q;
  assign pop  = valid_q & ~stall_i & ~flush_i;

  // Next pointer/occupancy state; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Next head entry. When the write lands in the slot that becomes the head,
  // the storage array is not yet updated, so forward the incoming entry.
  always_comb begin
    head_d = '{addr: '0, inst: NOP_INST};
    if (count_d != '0) begin
      if (push && !flush_i && (wr_ptr_q == rd_ptr_d)) begin
        head_d = in_entry;
      end else begin
        head_d = mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      head_q   <= '{addr: '0, inst: NOP_INST};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      ready_q  <= (count_d < CNT_W'(DEPTH));
      head_q   <= head_d;
    end
  end

  // Storage needs no reset; occupancy alone says which slots are live.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem[wr_ptr_q] <= in_entry;
    end
  end

  assign inst_ready_o = ready_q;
  assign inst_valid_o = valid_q;
  assign inst_addr_o  = head_q.addr;
  assign inst_o       = head_q.inst;
  assign count_o      = count_q;

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf: stimulus queues expected entries, a negedge
// monitor pops and compares them whenever decode consumes the head.
module tb_if_id_buf;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_addr_i, inst_i;
  logic        inst_valid_i, inst_ready_o;
  logic        stall_i, flush_i;
  logic [31:0] inst_addr_o, inst_o;
  logic        inst_valid_o;
  logic [1:0]  count_o;

  if_id_buf #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(2), .NOP_INST(NOP)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .inst_addr_i(inst_addr_i), .inst_i(inst_i),
    .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .stall_i(stall_i), .flush_i(flush_i),
    .inst_addr_o(inst_addr_o), .inst_o(inst_o),
    .inst_valid_o(inst_valid_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string name, input int cnt, input logic vld,
                          input logic rdy, input logic [31:0] addr, input logic [31:0] inst);
    chk({name, "_count"}, 32'(count_o), 32'(cnt));
    chk({name, "_valid"}, 32'(inst_valid_o), 32'(vld));
    chk({name, "_ready"}, 32'(inst_ready_o), 32'(rdy));
    chk({name, "_addr"}, inst_addr_o, addr);
    chk({name, "_inst"}, inst_o, inst);
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a << 12) ^ 32'h00000093;
  endfunction

  // One clock of stimulus; acc says whether this cycle's push is accepted.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] i,
                     input logic st, input logic fl, input logic acc);
    inst_valid_i = v;
    inst_addr_i  = a;
    inst_i       = i;
    stall_i      = st;
    flush_i      = fl;
    if (fl)  exp_q.delete();
    if (acc) exp_q.push_back('{addr: a, inst: i});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a pop happens at the next edge when the head is valid,
  // decode is not stalled and there is no flush.
  always @(negedge clk) begin
    if (rst_n) begin
      if (inst_valid_o && !stall_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual=%h required=none", inst_addr_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pop_addr", inst_addr_o, mon_e.addr);
          chk("pop_inst", inst_o, mon_e.inst);
        end
      end else if (!inst_valid_o) begin
        chk("empty_inst", inst_o, NOP);
        chk("empty_addr", inst_addr_o, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    logic [31:0] a;
    rst_n = 1'b0;
    inst_valid_i = 1'b0; inst_addr_i = '0; inst_i = '0;
    stall_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_head("reset", 0, 1'b0, 1'b1, 32'h0, NOP);
    rst_n = 1'b1;

    // Streaming: one push and one pop per cycle.
    cyc(1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0, 1'b1);
    chk_head("stream_a0", 1, 1'b1, 1'b1, 32'h0, 32'h00500093);
    cyc(1'b1, 32'h4, 32'h00100113, 1'b0, 1'b0, 1'b1);
    chk_head("stream_a1", 1, 1'b1, 1'b1, 32'h4, 32'h00100113);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_head("stream_done", 0, 1'b0, 1'b1, 32'h0, NOP);

    // Stall fill, then release.
    cyc(1'b1, 32'h8, inst_of(32'h8), 1'b1, 1'b0, 1'b1);
    chk_head("fill_1", 1, 1'b1, 1'b1, 32'h8, inst_of(32'h8));
    cyc(1'b1, 32'hC, inst_of(32'hC), 1'b1, 1'b0, 1'b1);
    chk_head("fill_2", 2, 1'b1, 1'b0, 32'h8, inst_of(32'h8));
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk_head("fill_hold", 2, 1'b1, 1'b0, 32'h8, inst_of(32'h8));
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_head("release_1", 1, 1'b1, 1'b1, 32'hC, inst_of(32'hC));
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_head("release_2", 0, 1'b0, 1'b1, 32'h0, NOP);

    // Flush with a full buffer, then flush with a push that would be accepted.
    cyc(1'b1, 32'h40, inst_of(32'h40), 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h44, inst_of(32'h44), 1'b1, 1'b0, 1'b1);
    chk("flush_pre_count", 32'(count_o), 32'd2);
    cyc(1'b1, 32'h10, inst_of(32'h10), 1'b0, 1'b1, 1'b0);
    chk_head("flush_full", 0, 1'b0, 1'b1, 32'h0, NOP);
    cyc(1'b1, 32'h48, inst_of(32'h48), 1'b1, 1'b0, 1'b1);
    chk_head("flush_pre1", 1, 1'b1, 1'b1, 32'h48, inst_of(32'h48));
    cyc(1'b1, 32'h14, inst_of(32'h14), 1'b0, 1'b1, 1'b0);
    chk_head("flush_push", 0, 1'b0, 1'b1, 32'h0, NOP);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_head("flush_after", 0, 1'b0, 1'b1, 32'h0, NOP);

    // Pointer wrap: valid every cycle, stall alternating 0/1; even cycles
    // after the first find the buffer full and the push is refused.
    idx = 0;
    for (int k = 0; k < 40 && idx < 7; k++) begin
      logic acc;
      acc = (k == 0) || (k % 2 == 1);
      a = 32'h20 + 32'(4 * idx);
      cyc(1'b1, a, inst_of(a), k[0], 1'b0, acc);
      if (acc) idx++;
      if (k == 1) chk_head("wrap_full", 2, 1'b1, 1'b0, 32'h20, inst_of(32'h20));
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_head("wrap_drained", 0, 1'b0, 1'b1, 32'h0, NOP);

    // Asynchronous reset between edges with two entries held.
    cyc(1'b1, 32'h50, inst_of(32'h50), 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h54, inst_of(32'h54), 1'b1, 1'b0, 1'b1);
    chk("areset_pre_count", 32'(count_o), 32'd2);
    inst_valid_i = 1'b0;
    stall_i = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_head("areset", 0, 1'b0, 1'b1, 32'h0, NOP);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 32'h60, inst_of(32'h60), 1'b0, 1'b0, 1'b1);
    chk_head("areset_push", 1, 1'b1, 1'b1, 32'h60, inst_of(32'h60));
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Full with pop: the offered push is refused, the slot frees next cycle.
    cyc(1'b1, 32'h70, inst_of(32'h70), 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h74, inst_of(32'h74), 1'b1, 1'b0, 1'b1);
    chk_head("fullpop_pre", 2, 1'b1, 1'b0, 32'h70, inst_of(32'h70));
    cyc(1'b1, 32'h78, inst_of(32'h78), 1'b0, 1'b0, 1'b0);
    chk_head("fullpop_1", 1, 1'b1, 1'b1, 32'h74, inst_of(32'h74));
    cyc(1'b1, 32'h78, inst_of(32'h78), 1'b0, 1'b0, 1'b1);
    chk_head("fullpop_2", 1, 1'b1, 1'b1, 32'h78, inst_of(32'h78));
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_head("fullpop_end", 0, 1'b0, 1'b1, 32'h0, NOP);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
